// File: rtl/mastermind_hint_evaluator_pkg.sv
// Shared definitions for the Mastermind hint evaluator.
//   MAX_PINS_COUNT : maximum number of pins on a row (array depth)
//   HINT_EVAL_STATE: evaluator FSM encoding
//   idx_w()        : index width for a given array depth (never zero)
package mastermind_hint_evaluator_pkg;

  localparam int MAX_PINS_COUNT = 20;

  typedef enum logic [1:0] {HE_IDLE, HE_GREEN, HE_YELLOW, HE_DONE} HINT_EVAL_STATE;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mastermind_hint_evaluator_index_counter.sv
// hint_pair_index_counter: nested i/j pin-index walker bounded by last_idx.
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart from (0,0)
//   en         : advance one step
//   pair_mode  : 1 = j inner loop / i outer loop, 0 = i only
//   last_idx   : n-1
//   i, j       : current indices
//   last       : current step is the final one of the walk; advancing wraps to (0,0)
module hint_pair_index_counter #(
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic             pair_mode,
  input  logic [IDX_W-1:0] last_idx,
  output logic [IDX_W-1:0] i,
  output logic [IDX_W-1:0] j,
  output logic             last
);

  logic i_last, j_last;

  assign i_last = (i == last_idx);
  assign j_last = (j == last_idx);
  assign last   = i_last && (!pair_mode || j_last);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      i <= '0;
      j <= '0;
    end else if (en) begin
      if (last) begin
        // wrap so the next phase starts at (0,0) without an extra clear
        i <= '0;
        j <= '0;
      end else if (pair_mode && !j_last) begin
        j <= j + IDX_W'(1);
      end else begin
        j <= '0;
        i <= i + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/mastermind_hint_evaluator.sv
// mastermind_hint_evaluator: green/yellow hint pair for one guess vs. the secret.
//   clk, reset  : clock, synchronous active-high reset
//   start       : request evaluation (honoured only when idle)
//   pins_count  : active pins n, clamped to MAX_PINS
//   guess       : guess pins, latched on accepted start
//   secret      : secret pins, latched on accepted start
//   busy        : evaluation in progress
//   done        : one-cycle completion pulse
//   green       : exact-position matches (held until next start)
//   yellow      : colour-only matches (held until next start)
// Green pass walks n pins, yellow pass walks all n*n pairs with one shared
// comparator; latency from accepted start to done is 1+n+n*n cycles.
module mastermind_hint_evaluator
  import mastermind_hint_evaluator_pkg::*;
#(
  parameter int MAX_PINS = MAX_PINS_COUNT,
  parameter int COLOR_W  = 8,
  parameter int CNT_W    = 8
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [CNT_W-1:0]                     pins_count,
  input  logic [0:MAX_PINS-1][COLOR_W-1:0]     guess,
  input  logic [0:MAX_PINS-1][COLOR_W-1:0]     secret,
  output logic                                 busy,
  output logic                                 done,
  output logic [CNT_W-1:0]                     green,
  output logic [CNT_W-1:0]                     yellow
);

  localparam int              IDX_W = idx_w(MAX_PINS);
  localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_PINS);

  HINT_EVAL_STATE state, state_nxt;

  logic [0:MAX_PINS-1][COLOR_W-1:0] g_lat, s_lat;
  logic [CNT_W-1:0]                 n_lat, n_clamped;
  logic [MAX_PINS-1:0]              ag_mask, as_mask;
  logic [IDX_W-1:0]                 idx_i, idx_j, last_idx, s_idx;
  logic                             walk_last, accept, colour_eq;

  assign accept    = (state == HE_IDLE) && start;
  assign n_clamped = (pins_count > MAX_N) ? MAX_N : pins_count;
  // n_lat==0 never enters a walk, so the wrapped value is don't-care there
  assign last_idx  = IDX_W'(n_lat - CNT_W'(1));
  assign busy      = (state != HE_IDLE);

  // single time-shared comparator: secret index is i in GREEN, j in YELLOW
  assign s_idx     = (state == HE_YELLOW) ? idx_j : idx_i;
  assign colour_eq = (g_lat[idx_i] == s_lat[s_idx]);

  hint_pair_index_counter #(.IDX_W(IDX_W)) u_idx (
    .clk      (clk),
    .reset    (reset),
    .clear    (accept),
    .en       ((state == HE_GREEN) || (state == HE_YELLOW)),
    .pair_mode(state == HE_YELLOW),
    .last_idx (last_idx),
    .i        (idx_i),
    .j        (idx_j),
    .last     (walk_last)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= HE_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HE_IDLE:   if (start) state_nxt = (n_clamped != '0) ? HE_GREEN : HE_DONE;
      HE_GREEN:  if (walk_last) state_nxt = HE_YELLOW;
      HE_YELLOW: if (walk_last) state_nxt = HE_DONE;
      HE_DONE:   state_nxt = HE_IDLE;
      default:   state_nxt = HE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done    <= 1'b0;
      green   <= '0;
      yellow  <= '0;
      ag_mask <= '0;
      as_mask <= '0;
      n_lat   <= '0;
      g_lat   <= '0;
      s_lat   <= '0;
    end else begin
      done <= (state == HE_DONE);
      if (accept) begin
        g_lat   <= guess;
        s_lat   <= secret;
        n_lat   <= n_clamped;
        green   <= '0;
        yellow  <= '0;
        ag_mask <= '0;
        as_mask <= '0;
      end else if (state == HE_GREEN) begin
        if (colour_eq) begin
          green          <= green + CNT_W'(1);
          ag_mask[idx_i] <= 1'b1;
          as_mask[idx_i] <= 1'b1;
        end
      end else if (state == HE_YELLOW) begin
        // marking ag[i] blocks later j from reusing the same guess pin
        if (!ag_mask[idx_i] && !as_mask[idx_j] && colour_eq) begin
          yellow         <= yellow + CNT_W'(1);
          ag_mask[idx_i] <= 1'b1;
          as_mask[idx_j] <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mastermind_hint_evaluator.sv
module tb_mastermind_hint_evaluator;

  typedef logic [0:19][7:0] pins_t;
  typedef struct {
    int g;
    int y;
    int lat;
    int t0;
    string name;
  } exp_t;

  logic        clk = 0, reset = 1, start = 0;
  logic [7:0]  pins_count = 0;
  pins_t       guess = '0, secret = '0;
  logic        busy, done;
  logic [7:0]  green, yellow;

  int checks = 0, errors = 0, cyc = 0;
  exp_t q[$];

  mastermind_hint_evaluator dut (
    .clk(clk), .reset(reset), .start(start), .pins_count(pins_count),
    .guess(guess), .secret(secret), .busy(busy), .done(done),
    .green(green), .yellow(yellow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic pins_t mk(input int a, b, c, d, input int fill);
    pins_t p;
    for (int k = 0; k < 20; k++) p[k] = 8'(fill);
    p[0] = 8'(a); p[1] = 8'(b); p[2] = 8'(c); p[3] = 8'(d);
    return p;
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // monitor: pops the scoreboard on every done pulse
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_green"}, int'(green), e.g);
        chk({e.name, "_yellow"}, int'(yellow), e.y);
        chk({e.name, "_latency"}, cyc - e.t0, e.lat);
      end
    end
  end

  task automatic issue(input string nm, input int n, input pins_t g, input pins_t s,
                       input int eg, input int ey, input int elat);
    exp_t e;
    @(negedge clk);
    pins_count = 8'(n); guess = g; secret = s; start = 1;
    @(posedge clk); #1;
    start = 0;
    e.g = eg; e.y = ey; e.lat = elat; e.t0 = cyc; e.name = nm;
    q.push_back(e);
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!busy && !done && q.size() == 0) begin ok = 1; break; end
    end
    if (!ok) chk({nm, "_timeout"}, 0, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_green", green, 0);
    chk("rst_yellow", yellow, 0);

    issue("t1_exact", 4, mk(1,2,3,4,0), mk(1,2,3,4,0), 4, 0, 21);
    wait_idle("t1");
    issue("t2_reverse", 4, mk(4,3,2,1,0), mk(1,2,3,4,0), 0, 4, 21);
    @(negedge clk); chk("t2_busy_early", busy, 1);
    repeat (18) @(negedge clk);
    chk("t2_busy_late", busy, 1);
    wait_idle("t2");
    issue("t3_dups", 4, mk(1,2,1,1,0), mk(1,1,2,2,0), 1, 2, 21);
    wait_idle("t3");
    issue("t4_n0", 0, mk(5,5,5,5,5), mk(5,5,5,5,5), 0, 0, 1);
    wait_idle("t4a");
    issue("t4_n25", 25, mk(5,5,5,5,5), mk(5,5,5,5,5), 20, 0, 421);
    wait_idle("t4b");
    issue("n1_miss", 1, mk(7,0,0,0,0), mk(9,0,0,0,0), 0, 0, 3);
    wait_idle("n1");
    // entries at index >= n would all be green if compared
    issue("upper_ignored", 3, mk(3,1,2,9,9), mk(1,2,3,9,9), 0, 3, 13);
    wait_idle("upper");

    // start pulses and input changes mid-run are ignored
    issue("t5_busy_start", 4, mk(1,2,3,4,0), mk(1,2,3,4,0), 4, 0, 21);
    repeat (3) @(negedge clk);
    guess = mk(8,8,8,8,8); secret = mk(6,6,6,6,6); pins_count = 8'd2; start = 1;
    @(negedge clk); start = 0;
    repeat (8) @(negedge clk);
    start = 1;
    @(negedge clk); start = 0;
    wait_idle("t5");
    repeat (5) @(negedge clk);
    chk("t5_hold_green", green, 4);
    chk("t5_hold_yellow", yellow, 0);
    chk("t5_hold_busy", busy, 0);

    // reset in YELLOW (green pass ends after 5 cycles for n=4)
    issue("t6_aborted", 4, mk(4,3,2,1,0), mk(1,2,3,4,0), 0, 4, 21);
    repeat (9) @(negedge clk);
    reset = 1;
    q.delete();
    @(posedge clk); #1;
    reset = 0;
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_green", green, 0);
    chk("t6_yellow", yellow, 0);
    repeat (25) @(negedge clk);
    chk("t6_no_done_busy", busy, 0);
    issue("t6_after", 4, mk(1,2,1,1,0), mk(1,1,2,2,0), 1, 2, 21);
    wait_idle("t6");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=0", 1);
    $fatal(1, "timeout");
  end

endmodule
